// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage: pipeline memory stage; issues dmem loads/stores, formats load data
// and registers the write_back result. Option MISALIGN_TRAP_EN. Rev 1.0
// ============================================================================
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [4:0]        in_rd_s,
    input  logic              in_regf_we,
    output logic              stall,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic              out_valid,
    output logic [6:0]        out_opcode,
    output logic [4:0]        out_rd_s,
    output logic [DATA_W-1:0] out_rd_v,
    output logic              out_regf_we
);

    localparam logic [6:0] OP_B_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_B_STORE = 7'b0100011;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;

    logic [6:0]        hold_opcode;
    logic [2:0]        hold_funct3;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_store_data;
    logic [4:0]        hold_rd_s;
    logic              hold_regf_we;

    logic              is_mem;
    logic              misaligned;
    logic              hold_is_store;
    logic [3:0]        hold_mask;

    // Masks wider than a word are truncated by the 4-bit result.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   byte_mask = 4'b0001 << off;
            2'b01:   byte_mask = 4'b0011 << off;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_format(input logic [2:0]        funct3,
                                                      input logic [1:0]        off,
                                                      input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0] lane;
        lane = rdata >> {off, 3'b000};
        case (funct3)
            3'b000:  load_format = {{(DATA_W-8){lane[7]}}, lane[7:0]};
            3'b100:  load_format = {{(DATA_W-8){1'b0}}, lane[7:0]};
            3'b001:  load_format = {{(DATA_W-16){lane[15]}}, lane[15:0]};
            3'b101:  load_format = {{(DATA_W-16){1'b0}}, lane[15:0]};
            default: load_format = rdata;
        endcase
    endfunction

    assign is_mem        = (in_opcode == OP_B_LOAD) || (in_opcode == OP_B_STORE);
    assign hold_is_store = (hold_opcode == OP_B_STORE);
    assign hold_mask     = byte_mask(hold_funct3[1:0], hold_addr[1:0]);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                        ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // dmem side is a pure function of state and the held request, so an
    // asynchronous reset (state -> IDLE) withdraws the request immediately.
    assign stall      = (state == S_WAIT) && in_valid;
    assign dmem_addr  = {hold_addr[ADDR_W-1:2], 2'b00};
    assign dmem_rmask = ((state == S_WAIT) && !hold_is_store) ? hold_mask : 4'b0000;
    assign dmem_wmask = ((state == S_WAIT) &&  hold_is_store) ? hold_mask : 4'b0000;
    assign dmem_wdata = (state == S_WAIT) ? (hold_store_data << {hold_addr[1:0], 3'b000})
                                          : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            hold_opcode     <= '0;
            hold_funct3     <= '0;
            hold_addr       <= '0;
            hold_store_data <= '0;
            hold_rd_s       <= '0;
            hold_regf_we    <= 1'b0;
            out_valid       <= 1'b0;
            out_opcode      <= '0;
            out_rd_s        <= '0;
            out_rd_v        <= '0;
            out_regf_we     <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            out_regf_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_mem && !misaligned) begin
                            hold_opcode     <= in_opcode;
                            hold_funct3     <= in_funct3;
                            hold_addr       <= in_addr;
                            hold_store_data <= in_store_data;
                            hold_rd_s       <= in_rd_s;
                            hold_regf_we    <= in_regf_we;
                            state           <= S_WAIT;
                        end else begin
                            // ALU result, or a trapped misaligned access
                            out_valid   <= 1'b1;
                            out_opcode  <= in_opcode;
                            out_rd_s    <= in_rd_s;
                            out_rd_v    <= DATA_W'(in_addr);
                            out_regf_we <= in_regf_we & ~is_mem;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_resp) begin
                        state      <= S_IDLE;
                        out_valid  <= 1'b1;
                        out_opcode <= hold_opcode;
                        out_rd_s   <= hold_rd_s;
                        if (hold_is_store) begin
                            out_rd_v    <= '0;
                            out_regf_we <= 1'b0;
                        end else begin
                            out_rd_v    <= load_format(hold_funct3, hold_addr[1:0], dmem_rdata);
                            out_regf_we <= hold_regf_we;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// tb_mem_stage: directed literal checks plus randomized traffic compared every
// cycle against a transaction-level model of the memory stage.
module tb_mem_stage;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd_s;
    logic        in_regf_we;
    logic        stall;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        out_valid;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd_s;
    logic [31:0] out_rd_v;
    logic        out_regf_we;

    int checks = 0;
    int errors = 0;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_opcode     (in_opcode),
        .in_funct3     (in_funct3),
        .in_addr       (in_addr),
        .in_store_data (in_store_data),
        .in_rd_s       (in_rd_s),
        .in_regf_we    (in_regf_we),
        .stall         (stall),
        .dmem_addr     (dmem_addr),
        .dmem_rmask    (dmem_rmask),
        .dmem_wmask    (dmem_wmask),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_resp     (dmem_resp),
        .out_valid     (out_valid),
        .out_opcode    (out_opcode),
        .out_rd_s      (out_rd_s),
        .out_rd_v      (out_rd_v),
        .out_regf_we   (out_regf_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] mdl_mask(input logic [2:0] f3, input logic [31:0] a);
        int off;
        int n;
        logic [3:0] m;
        off = int'(a % 4);
        n = size_of(f3);
        m = 4'h0;
        if (n == 4) return 4'hF;
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + n) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
        int off;
        int n;
        longint v;
        off = int'(a % 4);
        n = size_of(f3);
        if (n == 4) return rdata;
        v = 0;
        for (int k = 0; k < n; k++)
            if (off + k < 4)
                v = v + (longint'((rdata >> (8 * (off + k))) & 32'hFF) << (8 * k));
        if (!f3[2] && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [31:0] sd, input logic [31:0] a);
        longint w;
        w = longint'(sd) * (longint'(1) << (8 * int'(a % 4)));
        return 32'(w);
    endfunction

    function automatic bit mdl_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (size_of(f3) == 2 && (a % 2) == 1) || (size_of(f3) == 4 && (a % 4) != 0);
`else
        return (f3 == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    bit          busy = 1'b0;
    logic [6:0]  p_op = '0;
    logic [2:0]  p_f3 = '0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_sd = '0;
    logic [4:0]  p_rd = '0;
    logic        p_we = 1'b0;
    logic        ev = 1'b0;
    logic        ewe = 1'b0;
    logic [31:0] erd_v = '0;
    logic [4:0]  ers = '0;
    logic [6:0]  eop = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 1'b0;
            ev   = 1'b0;
            ewe  = 1'b0;
        end else if (busy) begin
            ev  = 1'b0;
            ewe = 1'b0;
            if (dmem_resp) begin
                busy = 1'b0;
                ev   = 1'b1;
                ers  = p_rd;
                eop  = p_op;
                if (p_op == STORE) begin
                    erd_v = 32'h0;
                end else begin
                    erd_v = mdl_load(p_f3, p_addr, dmem_rdata);
                    ewe   = p_we;
                end
            end
        end else begin
            ev  = 1'b0;
            ewe = 1'b0;
            if (in_valid) begin
                if ((in_opcode == LOAD || in_opcode == STORE) && !mdl_misaligned(in_funct3, in_addr)) begin
                    busy   = 1'b1;
                    p_op   = in_opcode;
                    p_f3   = in_funct3;
                    p_addr = in_addr;
                    p_sd   = in_store_data;
                    p_rd   = in_rd_s;
                    p_we   = in_regf_we;
                end else begin
                    ev    = 1'b1;
                    erd_v = in_addr;
                    ers   = in_rd_s;
                    eop   = in_opcode;
                    ewe   = (in_opcode == LOAD || in_opcode == STORE) ? 1'b0 : in_regf_we;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic is_st;
        is_st = (p_op == STORE);
        chk("stall", {31'b0, stall}, {31'b0, busy && in_valid});
        chk("rmask", {28'b0, dmem_rmask}, {28'b0, (busy && !is_st) ? mdl_mask(p_f3, p_addr) : 4'h0});
        chk("wmask", {28'b0, dmem_wmask}, {28'b0, (busy && is_st) ? mdl_mask(p_f3, p_addr) : 4'h0});
        if (busy) begin
            chk("dmem_addr", dmem_addr, p_addr - (p_addr % 4));
            if (is_st) chk("wdata", dmem_wdata, mdl_wdata(p_sd, p_addr));
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
        chk("out_regf_we", {31'b0, out_regf_we}, {31'b0, ewe});
        if (ev) begin
            chk("out_rd_v", out_rd_v, erd_v);
            chk("out_rd_s", {27'b0, out_rd_s}, {27'b0, ers});
            chk("out_opcode", {25'b0, out_opcode}, {25'b0, eop});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic we);
        in_valid = v; in_opcode = op; in_funct3 = f3;
        in_addr = a; in_store_data = sd; in_rd_s = rd; in_regf_we = we;
    endtask

    task automatic idle();
        drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  lb_f3  [2];
        logic [31:0] lb_exp [2];
        logic [2:0]  ld_f3s [5];
        logic [6:0]  op;
        bit          hold;
        int          kind;

        idle();
        dmem_resp = 1'b0;
        dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_rmask", {28'b0, dmem_rmask}, 32'h0);
        chk("rst_wmask", {28'b0, dmem_wmask}, 32'h0);
        chk("rst_rd_v", out_rd_v, 32'h0);

        // ALU op, 1-cycle latency
        drive(1'b1, ALU, 3'h0, 32'h1234, 32'h0, 5'd5, 1'b1);
        #1 chk("alu_stall", {31'b0, stall}, 32'h0);
        step();
        chk("alu_valid", {31'b0, out_valid}, 32'h1);
        chk("alu_rd_v", out_rd_v, 32'h1234);
        chk("alu_rd_s", {27'b0, out_rd_s}, 32'd5);
        chk("alu_we", {31'b0, out_regf_we}, 32'h1);
        idle();

        // lw with response in the third WAIT cycle
        drive(1'b1, LOAD, 3'b010, 32'h100, 32'h0, 5'd7, 1'b1);
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                dmem_resp = 1'b1;
                dmem_rdata = 32'hDEADBEEF;
            end
            #1;
            chk("lw_addr", dmem_addr, 32'h100);
            chk("lw_rmask", {28'b0, dmem_rmask}, 32'hF);
            chk("lw_wait_valid", {31'b0, out_valid}, 32'h0);
            step();
        end
        dmem_resp = 1'b0;
        chk("lw_valid", {31'b0, out_valid}, 32'h1);
        chk("lw_rd_v", out_rd_v, 32'hDEADBEEF);

        // lb / lbu at offset 3
        lb_f3[0] = 3'b000; lb_exp[0] = 32'hFFFFFF80;
        lb_f3[1] = 3'b100; lb_exp[1] = 32'h00000080;
        for (int j = 0; j < 2; j++) begin
            drive(1'b1, LOAD, lb_f3[j], 32'h203, 32'h0, 5'd9, 1'b1);
            step();
            idle();
            dmem_resp = 1'b1;
            dmem_rdata = 32'h80FFFFFF;
            #1 chk("lb_rmask", {28'b0, dmem_rmask}, 32'h8);
            step();
            dmem_resp = 1'b0;
            chk("lb_rd_v", out_rd_v, lb_exp[j]);
        end

        // sh at offset 2
        drive(1'b1, STORE, 3'b001, 32'h302, 32'h0000ABCD, 5'd3, 1'b1);
        step();
        idle();
        #1;
        chk("sh_wmask", {28'b0, dmem_wmask}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCD0000);
        chk("sh_rmask", {28'b0, dmem_rmask}, 32'h0);
        dmem_resp = 1'b1;
        step();
        dmem_resp = 1'b0;
        chk("sh_valid", {31'b0, out_valid}, 32'h1);
        chk("sh_we", {31'b0, out_regf_we}, 32'h0);

        // back-to-back lw then ALU
        drive(1'b1, LOAD, 3'b010, 32'h40, 32'h0, 5'd4, 1'b1);
        step();
        drive(1'b1, ALU, 3'h0, 32'h5A5A, 32'h0, 5'd6, 1'b1);
        #1 chk("b2b_stall_w1", {31'b0, stall}, 32'h1);
        step();
        dmem_resp = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        #1 chk("b2b_stall_w2", {31'b0, stall}, 32'h1);
        step();
        dmem_resp = 1'b0;
        chk("b2b_lw_valid", {31'b0, out_valid}, 32'h1);
        chk("b2b_lw_rd_s", {27'b0, out_rd_s}, 32'd4);
        chk("b2b_lw_rd_v", out_rd_v, 32'h0BADF00D);
        #1 chk("b2b_stall_idle", {31'b0, stall}, 32'h0);
        step();
        chk("b2b_alu_valid", {31'b0, out_valid}, 32'h1);
        chk("b2b_alu_rd_v", out_rd_v, 32'h5A5A);
        chk("b2b_alu_rd_s", {27'b0, out_rd_s}, 32'd6);
        idle();

        // asynchronous reset during WAIT
        drive(1'b1, LOAD, 3'b010, 32'h80, 32'h0, 5'd2, 1'b1);
        step();
        drive(1'b1, ALU, 3'h0, 32'h77, 32'h0, 5'd1, 1'b1);
        #1;
        chk("rstw_rmask_pre", {28'b0, dmem_rmask}, 32'hF);
        chk("rstw_stall_pre", {31'b0, stall}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_rmask", {28'b0, dmem_rmask}, 32'h0);
        chk("rstw_wmask", {28'b0, dmem_wmask}, 32'h0);
        chk("rstw_stall", {31'b0, stall}, 32'h0);
        idle();
        repeat (2) step();
        rst_n = 1'b1;
        dmem_resp = 1'b1;
        dmem_rdata = 32'h12345678;
        step();
        dmem_resp = 1'b0;
        chk("rstw_late_resp", {31'b0, out_valid}, 32'h0);
        step();
        chk("rstw_valid_after", {31'b0, out_valid}, 32'h0);

        // randomized traffic
        ld_f3s[0] = 3'b000; ld_f3s[1] = 3'b001; ld_f3s[2] = 3'b010;
        ld_f3s[3] = 3'b100; ld_f3s[4] = 3'b101;
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                kind = int'($urandom_range(0, 2));
                if (kind == 0) begin
                    op = LOAD;
                    in_funct3 = ld_f3s[$urandom_range(0, 4)];
                end else if (kind == 1) begin
                    op = STORE;
                    in_funct3 = 3'($urandom_range(0, 2));
                end else begin
                    op = 7'($urandom());
                    if (op == LOAD || op == STORE) op = ALU;
                    in_funct3 = 3'($urandom());
                end
                in_opcode     = op;
                in_valid      = ($urandom_range(0, 3) != 0);
                in_addr       = $urandom();
                in_store_data = $urandom();
                in_rd_s       = 5'($urandom());
                in_regf_we    = 1'($urandom());
            end
            dmem_resp  = ($urandom_range(0, 2) == 0);
            dmem_rdata = $urandom();
            #1 hold = stall;
            @(posedge clk);
            #1;
        end
        idle();
        dmem_resp = 1'b0;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
